vector_serialize_12: RTL

Consumer-side counterpart of the 12-lane registered vector adder. It captures a full 12-element result vector on the adder's ready strobe, then streams the elements out one per accepted beat, lane 0 first, over a valid/acknowledge handshake. This lets a narrow downstream stage (accumulator, memory writer, UART framer) drain matrix-add rows without 12 parallel buses.

---
 rtl/vecser_pkg.sv | 21 ++
 rtl/vector_capture_reg_12.sv | 54 +++++
 rtl/vector_serialize_12.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vecser_pkg.sv
// ---------------------------------------------------------------------------
// vecser_pkg
// Shared definitions for the 12-lane vector serializer.
//   VEC_LEN  : number of lanes in a captured vector
//   IDX_W    : width of the lane index counter
//   LAST_IDX : index of the final lane (outLast is high on this lane)
//   state_t  : serializer FSM states (IDLE, SEND)
// ---------------------------------------------------------------------------
package vecser_pkg;

    localparam int VEC_LEN = 12;
    localparam int IDX_W   = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/vector_capture_reg_12.sv
// ---------------------------------------------------------------------------
// vector_capture_reg_12
// Twelve-lane register bank. All lanes are loaded together when en_i and
// load_i are both high. A combinational indexed read mux selects one lane.
//
// Ports:
//   clk        : clock, rising edge
//   reset_i    : synchronous active-high reset, clears every lane
//   en_i       : clock enable, gates the load
//   load_i     : load strobe, captures data_i into all lanes
//   data_i     : twelve lanes to capture, lane 0 in the lowest slice
//   rd_idx_i   : lane to present on rd_data_o (out-of-range reads give 0)
//   rd_data_o  : selected lane
//   vec_o      : all lanes, used when the bank feeds another bank
// ---------------------------------------------------------------------------
module vector_capture_reg_12
    import vecser_pkg::*;
#(
    parameter int DATA_WIDTH = 11
) (
    input  logic                                  clk,
    input  logic                                  reset_i,
    input  logic                                  en_i,
    input  logic                                  load_i,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]    data_i,
    input  logic [IDX_W-1:0]                      rd_idx_i,
    output logic [DATA_WIDTH-1:0]                 rd_data_o,
    output logic [VEC_LEN-1:0][DATA_WIDTH-1:0]    vec_o
);

    for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_q;

        always_ff @(posedge clk) begin
            if (reset_i) begin
                lane_q <= '0;
            end else if (en_i && load_i) begin
                lane_q <= data_i[gi];
            end
        end

        assign vec_o[gi] = lane_q;
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_data_o = vec_o[i];
            end
        end
    end

endmodule

// File: rtl/vector_serialize_12.sv
// ---------------------------------------------------------------------------
// vector_serialize_12
// Captures a 12-element vector on the inReady strobe and streams it out one
// element per acknowledged beat, lane 0 first, over an outReady/outAck
// handshake. A new strobe on the final acknowledged beat is taken without
// a bubble; any other strobe during streaming is either parked in a shadow
// bank (double-buffer build) or dropped with an overrun pulse.
//
// Build option:
//   VECSER_DOUBLE_BUFFER_EN : when defined, adds a one-deep shadow vector
//                             so a strobe during streaming is kept.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   enable    : global clock enable, all state holds when low
//   inReady   : single-cycle strobe, V0..V11 valid
//   V0..V11   : signed elements to capture
//   outAck    : downstream accepts the current element
//   outReady  : outData/outIndex valid
//   outData   : current element (registered)
//   outIndex  : lane number of outData (registered)
//   outLast   : high with lane 11 (registered)
//   busy      : a vector is being streamed or is waiting in the shadow
//   overrun   : one-cycle pulse, a strobe was dropped the previous cycle
// ---------------------------------------------------------------------------
module vector_serialize_12
    import vecser_pkg::*;
#(
    parameter int DATA_WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         inReady,
    input  logic signed [DATA_WIDTH-1:0] V0,
    input  logic signed [DATA_WIDTH-1:0] V1,
    input  logic signed [DATA_WIDTH-1:0] V2,
    input  logic signed [DATA_WIDTH-1:0] V3,
    input  logic signed [DATA_WIDTH-1:0] V4,
    input  logic signed [DATA_WIDTH-1:0] V5,
    input  logic signed [DATA_WIDTH-1:0] V6,
    input  logic signed [DATA_WIDTH-1:0] V7,
    input  logic signed [DATA_WIDTH-1:0] V8,
    input  logic signed [DATA_WIDTH-1:0] V9,
    input  logic signed [DATA_WIDTH-1:0] V10,
    input  logic signed [DATA_WIDTH-1:0] V11,
    input  logic                         outAck,
    output logic                         outReady,
    output logic signed [DATA_WIDTH-1:0] outData,
    output logic [IDX_W-1:0]             outIndex,
    output logic                         outLast,
    output logic                         busy,
    output logic                         overrun
);

`ifdef VECSER_DOUBLE_BUFFER_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    state_t                               state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic                                 sh_full_q;
    logic                                 sh_full_d;
    logic                                 vec_load;
    logic                                 vec_from_sh;
    logic                                 sh_load;
    logic                                 drop;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   in_vec;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   vec_src;
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0]   vec_all_unused;
    logic [DATA_WIDTH-1:0]                vec_rd;
    logic [DATA_WIDTH-1:0]                out_data_d;
    logic signed [DATA_WIDTH-1:0]         out_data_q;
    logic                                 out_last_q;
    logic                                 overrun_q;

    assign in_vec = {V11, V10, V9, V8, V7, V6, V5, V4, V3, V2, V1, V0};

    // ---------------------------------------------------------------------
    // Next-state logic. Nothing moves while enable is low, so a strobe in
    // that window is neither captured nor reported.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sh_full_d   = sh_full_q;
        vec_load    = 1'b0;
        vec_from_sh = 1'b0;
        sh_load     = 1'b0;
        drop        = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (inReady) begin
                        vec_load = 1'b1;
                        idx_d    = '0;
                        state_d  = SEND;
                    end
                end
                SEND: begin
                    if (outAck && (idx_q == LAST_IDX)) begin
                        // Final beat: refill from shadow first, then from the
                        // live strobe, otherwise go idle.
                        idx_d = '0;
                        if (sh_full_q) begin
                            vec_load    = 1'b1;
                            vec_from_sh = 1'b1;
                            sh_load     = inReady;
                            sh_full_d   = inReady;
                        end else if (inReady) begin
                            vec_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (outAck) begin
                            idx_d = idx_q + 1'b1;
                        end
                        if (inReady) begin
                            if (DBUF && !sh_full_q) begin
                                sh_load   = 1'b1;
                                sh_full_d = 1'b1;
                            end else begin
                                drop = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef VECSER_DOUBLE_BUFFER_EN
    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] sh_all;
    logic [DATA_WIDTH-1:0]              sh_rd_unused;

    vector_capture_reg_12 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow (
        .clk       (clk),
        .reset_i   (reset),
        .en_i      (enable),
        .load_i    (sh_load),
        .data_i    (in_vec),
        .rd_idx_i  ('0),
        .rd_data_o (sh_rd_unused),
        .vec_o     (sh_all)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_full_q <= 1'b0;
        end else if (enable) begin
            sh_full_q <= sh_full_d;
        end
    end

    assign vec_src = vec_from_sh ? sh_all : in_vec;
`else
    logic unused_sh;

    assign sh_full_q = 1'b0;
    assign vec_src   = in_vec;
    assign unused_sh = ^{sh_load, sh_full_d, vec_from_sh};
`endif

    vector_capture_reg_12 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_vec (
        .clk       (clk),
        .reset_i   (reset),
        .en_i      (enable),
        .load_i    (vec_load),
        .data_i    (vec_src),
        .rd_idx_i  (idx_d),
        .rd_data_o (vec_rd),
        .vec_o     (vec_all_unused)
    );

    // On a load the bank still holds the old vector this cycle, so lane 0
    // of the incoming source is forwarded straight into the output register.
    assign out_data_d = vec_load ? vec_src[0] : vec_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= drop;
            if (enable) begin
                state_q    <= state_d;
                idx_q      <= idx_d;
                out_data_q <= out_data_d;
                out_last_q <= (state_d == SEND) && (idx_d == LAST_IDX);
            end
        end
    end

    assign outReady = (state_q == SEND);
    assign outData  = out_data_q;
    assign outIndex = idx_q;
    assign outLast  = out_last_q;
    assign busy     = (state_q == SEND) || sh_full_q;
    assign overrun  = overrun_q;

endmodule
